// File: rtl/dbg_pkg.sv
// Shared types and widths for the debug register-read port.
package dbg_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;
    localparam int SETTLE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/reg_dump_scanner.sv
// Sweeps the CPU debug register-read port and streams each word out
// on a valid/ready interface, tagged with its index and a last flag.
module reg_dump_scanner
    import dbg_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int SETTLE   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic [REG_IDX_W-1:0]  reg_sel,
    input  logic [REG_DATA_W-1:0] reg_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_DATA_W-1:0] out_data,
    output logic [REG_IDX_W-1:0]  out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX    = REG_IDX_W'(NUM_REGS - 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_INIT = SETTLE_W'(SETTLE);
    localparam logic [SETTLE_W-1:0]  CNT_ONE     = SETTLE_W'(1);

    state_e              state;
    logic [SETTLE_W-1:0] cnt;

    // rstn is an active-high asynchronous reset despite its name
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            reg_sel   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        reg_sel <= '0;
                        cnt     <= SETTLE_INIT;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        out_data  <= reg_data;
                        out_idx   <= reg_sel;
                        out_last  <= (reg_sel == LAST_IDX);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            reg_sel <= reg_sel + 5'd1;
                            cnt     <= SETTLE_INIT;
                            state   <= WAIT;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed bench for reg_dump_scanner: default sweep plus a
// SETTLE=3 / NUM_REGS=4 instance with a slow-settling register file.
module tb_reg_dump_scanner;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_a, start_b;
    logic        ready_a, ready_b;
    logic [4:0]  sel_a, sel_b, idx_a, idx_b;
    logic [31:0] rd_a, rd_b, d_a, d_b;
    logic        v_a, v_b, last_a, last_b;
    logic        busy_a, busy_b, done_a, done_b;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    assign rd_a = 32'h1000_0000 + {27'd0, sel_a};

    // instance B register file reads as X for two cycles after reg_sel moves
    logic [4:0] last_sel_b = '0;
    int         xleft_b    = 0;
    always @(negedge clk) begin
        if (sel_b != last_sel_b) xleft_b <= 2;
        else if (xleft_b != 0) xleft_b <= xleft_b - 1;
        last_sel_b <= sel_b;
    end
    assign rd_b = (xleft_b != 0) ? 32'hxxxx_xxxx
                                 : 32'hDEAD_0000 + {27'd0, sel_b};

    reg_dump_scanner u_a (
        .clk(clk), .rstn(rstn), .start(start_a),
        .reg_sel(sel_a), .reg_data(rd_a),
        .out_valid(v_a), .out_ready(ready_a),
        .out_data(d_a), .out_idx(idx_a), .out_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    reg_dump_scanner #(.NUM_REGS(4), .SETTLE(3)) u_b (
        .clk(clk), .rstn(rstn), .start(start_b),
        .reg_sel(sel_b), .reg_data(rd_b),
        .out_valid(v_b), .out_ready(ready_b),
        .out_data(d_b), .out_idx(idx_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // word monitor for instance A
    bit mon_a = 1'b0;
    int exp_a = 0, nw_a = 0, nd_a = 0;
    int first_a = -1, done_edge_a = 0, e0_a = 0;

    always @(negedge clk) begin
        if (mon_a) begin
            if (v_a && first_a < 0) first_a = edge_n;
            if (v_a && ready_a) begin
                chk("a_idx", {27'd0, idx_a}, 32'(exp_a));
                chk("a_data", d_a, 32'h1000_0000 + 32'(exp_a));
                chk("a_last", {31'd0, last_a}, 32'(exp_a == 31));
                exp_a++;
                nw_a++;
            end
            if (done_a) begin
                nd_a++;
                done_edge_a = edge_n;
            end
        end
    end

    task automatic begin_sweep_a();
        exp_a   = 0;
        nw_a    = 0;
        nd_a    = 0;
        first_a = -1;
        mon_a   = 1'b1;
        start_a = 1'b1;
        tick();
        e0_a    = edge_n;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a();
        int k = 0;
        while (nd_a == 0 && k < 400) begin
            tick();
            k++;
        end
        if (nd_a == 0) chk("a_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idx_a(input int idx);
        int  k = 0;
        bit  hit = 1'b0;
        while (!hit && k < 400) begin
            tick();
            k++;
            if (v_a && idx_a == 5'(idx)) hit = 1'b1;
        end
        if (!hit) chk("a_idx_timeout", 32'd0, 32'(idx));
    endtask

    initial begin
        int k;
        int e0_b, first_b, done_edge_b, exp_b;
        bit fin_b;

        rstn    = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        #12;
        chk("rst_sel", {27'd0, sel_a}, 32'd0);
        chk("rst_valid", {31'd0, v_a}, 32'd0);
        chk("rst_data", d_a, 32'd0);
        chk("rst_idx", {27'd0, idx_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        rstn = 1'b0;
        tick();

        // full sweep with out_ready tied high
        begin_sweep_a();
        wait_done_a();
        chk("full_words", 32'(nw_a), 32'd32);
        chk("full_done_cnt", 32'(nd_a), 32'd1);
        chk("full_first_lat", 32'(first_a - e0_a), 32'd1);
        chk("full_done_edge", 32'(done_edge_a - e0_a), 32'd64);
        chk("full_busy_end", {31'd0, busy_a}, 32'd0);

        // start while busy, then start during the DONE cycle
        begin_sweep_a();
        wait_idx_a(10);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (!done_a && k < 400) begin
            tick();
            k++;
        end
        chk("sb_done_seen", {31'd0, done_a}, 32'd1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("sb_busy_after", {31'd0, busy_a}, 32'd0);
        tick();
        chk("sb_idle_busy", {31'd0, busy_a}, 32'd0);
        chk("sb_idle_valid", {31'd0, v_a}, 32'd0);
        chk("sb_words", 32'(nw_a), 32'd32);
        chk("sb_done_cnt", 32'(nd_a), 32'd1);

        // backpressure at idx 3
        begin_sweep_a();
        wait_idx_a(3);
        ready_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'd0, v_a}, 32'd1);
            chk("bp_data", d_a, 32'h1000_0003);
            chk("bp_idx", {27'd0, idx_a}, 32'd3);
            chk("bp_sel", {27'd0, sel_a}, 32'd3);
        end
        ready_a = 1'b1;
        wait_done_a();
        chk("bp_words", 32'(nw_a), 32'd32);
        chk("bp_done_cnt", 32'(nd_a), 32'd1);

        // asynchronous reset while holding idx 7 in SEND
        begin_sweep_a();
        wait_idx_a(7);
        ready_a = 1'b0;
        #3;
        rstn = 1'b1;
        #1;
        chk("mr_valid", {31'd0, v_a}, 32'd0);
        chk("mr_data", d_a, 32'd0);
        chk("mr_idx", {27'd0, idx_a}, 32'd0);
        chk("mr_last", {31'd0, last_a}, 32'd0);
        chk("mr_sel", {27'd0, sel_a}, 32'd0);
        chk("mr_busy", {31'd0, busy_a}, 32'd0);
        #2;
        rstn    = 1'b0;
        ready_a = 1'b1;
        tick();
        tick();
        chk("mr_no_done", 32'(nd_a), 32'd0);
        chk("mr_idle", {31'd0, busy_a}, 32'd0);
        begin_sweep_a();
        wait_done_a();
        chk("mr_words", 32'(nw_a), 32'd32);
        chk("mr_done_cnt", 32'(nd_a), 32'd1);
        mon_a = 1'b0;

        // SETTLE=3, NUM_REGS=4 with X-settling register data
        start_b = 1'b1;
        tick();
        e0_b    = edge_n;
        start_b = 1'b0;
        first_b = -1;
        done_edge_b = 0;
        exp_b   = 0;
        fin_b   = 1'b0;
        k = 0;
        while (!fin_b && k < 200) begin
            @(negedge clk);
            k++;
            if (v_b && first_b < 0) first_b = edge_n;
            if (v_b && ready_b) begin
                chk("b_idx", {27'd0, idx_b}, 32'(exp_b));
                chk("b_data", d_b, 32'hDEAD_0000 + 32'(exp_b));
                chk("b_last", {31'd0, last_b}, 32'(exp_b == 3));
                exp_b++;
            end
            if (done_b) begin
                done_edge_b = edge_n;
                fin_b = 1'b1;
            end
        end
        if (!fin_b) chk("b_done_timeout", 32'd0, 32'd1);
        chk("b_words", 32'(exp_b), 32'd4);
        chk("b_first_lat", 32'(first_b - e0_b), 32'd3);
        chk("b_done_edge", 32'(done_edge_b - e0_b), 32'd16);
        tick();
        tick();
        chk("b_busy_end", {31'd0, busy_b}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
